// File: rtl/pi_bus_arbiter.sv
// pi_bus_arbiter: time-slices the 17-bit RAM bus between the Pi bridge and the
// 6502 over a fixed frame. The first half of each frame is the Pi slot and the
// second half is the CPU slot. This block also generates phi2 and every RAM strobe.
// All strobes are registered from the next-count value, so each output is
// aligned with the count value that the frame counter holds in the same clock.
`timescale 1ns/1ps

module pi_bus_arbiter #(
    parameter int FRAME_LEN   = 16,
    parameter int PI_SLOT_END = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pi_pending,
    input  logic [16:0] pi_addr,
    input  logic [7:0]  pi_data_out,
    input  logic        pi_rw_b,
    output logic        pi_done,
    output logic [7:0]  pi_data_in,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw_b,
    output logic        phi2,
    output logic        cpu_be,
    output logic [16:0] ram_addr,
    input  logic [7:0]  ram_data_i,
    output logic [7:0]  ram_data_o,
    output logic        ram_data_oe,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    localparam int CW = $clog2(FRAME_LEN);

    localparam logic [CW-1:0] CNT_LAST     = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] SLOT_END     = CW'(PI_SLOT_END);
    localparam logic [CW-1:0] PI_OE_FIRST  = CW'(2);
    localparam logic [CW-1:0] PI_OE_LAST   = CW'(PI_SLOT_END - 1);
    localparam logic [CW-1:0] PI_WE_FIRST  = CW'(3);
    localparam logic [CW-1:0] PI_WE_LAST   = CW'(PI_SLOT_END - 2);
    localparam logic [CW-1:0] CPU_OE_FIRST = CW'(PI_SLOT_END + 2);
    localparam logic [CW-1:0] CPU_WE_FIRST = CW'(PI_SLOT_END + 3);
    localparam logic [CW-1:0] CPU_WE_LAST  = CW'(FRAME_LEN - 2);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [CW-1:0] count, count_nxt;
    logic [1:0]    sync_q;
    logic          pend_s;
    logic [1:0]    state, state_nxt;
    logic          done_nxt;
    logic [16:0]   lat_addr, lat_addr_nxt;
    logic [7:0]    lat_data, lat_data_nxt;
    logic          lat_rw, lat_rw_nxt;
    logic [16:0]   addr_nxt;
    logic [7:0]    data_o_nxt;
    logic          data_oe_nxt, oe_n_nxt, we_n_nxt;

    assign pend_s = sync_q[1];

    // Frame counter advance and Pi request state machine.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_nxt    = (count == CNT_LAST) ? '0 : count + CW'(1);
        state_nxt    = state;
        done_nxt     = pi_done;
        lat_addr_nxt = lat_addr;
        lat_data_nxt = lat_data;
        lat_rw_nxt   = lat_rw;
        case (state)
            ST_IDLE: begin
                if (count == '0 && pend_s && !pi_done) begin
                    state_nxt    = ST_ACCESS;
                    lat_addr_nxt = pi_addr;
                    lat_data_nxt = pi_data_out;
                    lat_rw_nxt   = pi_rw_b;
                end
            end
            ST_ACCESS: begin
                // The access always runs to the end of the slot; a dropped
                // request only suppresses the done handshake.
                if (count == SLOT_END) begin
                    if (pend_s) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (!pend_s) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b0;
            end
        endcase
    end

    // RAM strobe decode for the count about to be entered; Pi slot first, CPU slot otherwise.
    always_comb begin
        addr_nxt    = ram_addr;
        data_o_nxt  = ram_data_o;
        data_oe_nxt = 1'b0;
        oe_n_nxt    = 1'b1;
        we_n_nxt    = 1'b1;
        if (state_nxt == ST_ACCESS) begin
            // ACCESS is only ever occupied over counts 1..PI_SLOT_END.
            addr_nxt = lat_addr_nxt;
            if (lat_rw_nxt) begin
                oe_n_nxt = !(count_nxt >= PI_OE_FIRST && count_nxt <= PI_OE_LAST);
            end else begin
                data_oe_nxt = 1'b1;
                data_o_nxt  = lat_data_nxt;
                we_n_nxt    = !(count_nxt >= PI_WE_FIRST && count_nxt <= PI_WE_LAST);
            end
        end else if (count_nxt > SLOT_END) begin
            addr_nxt = {1'b0, cpu_addr};
            if (cpu_rw_b) begin
                oe_n_nxt = !(count_nxt >= CPU_OE_FIRST);
            end else begin
                we_n_nxt = !(count_nxt >= CPU_WE_FIRST && count_nxt <= CPU_WE_LAST);
            end
        end
    end

    // Frame counter, request synchronizer, FSM and latched Pi request.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            sync_q   <= 2'b00;
            state    <= ST_IDLE;
            pi_done  <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_rw   <= 1'b1;
        end else begin
            count    <= count_nxt;
            sync_q   <= {sync_q[0], pi_pending};
            state    <= state_nxt;
            pi_done  <= done_nxt;
            lat_addr <= lat_addr_nxt;
            lat_data <= lat_data_nxt;
            lat_rw   <= lat_rw_nxt;
        end
    end

    // Registered bus outputs: phi2/cpu_be and RAM strobes aligned with count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phi2        <= 1'b0;
            cpu_be      <= 1'b0;
            ram_addr    <= '0;
            ram_data_o  <= '0;
            ram_data_oe <= 1'b0;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
        end else begin
            phi2        <= (count_nxt > SLOT_END);
            cpu_be      <= (count_nxt > SLOT_END);
            ram_addr    <= addr_nxt;
            ram_data_o  <= data_o_nxt;
            ram_data_oe <= data_oe_nxt;
            ram_oe_n    <= oe_n_nxt;
            ram_we_n    <= we_n_nxt;
        end
    end

    // Pi read data capture on the last edge of the read strobe; held until the next Pi read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pi_data_in <= '0;
        end else if (state == ST_ACCESS && lat_rw && count == PI_OE_LAST) begin
            pi_data_in <= ram_data_i;
        end
    end

endmodule

// File: doc/pi_bus_arbiter.md
# pi_bus_arbiter

Shares the PET's 17-bit RAM bus between the 6502 and the Pi bridge by time-slicing a fixed 16-clock bus frame. It runs on the system clock and generates phi2 and all RAM strobes. Each frame has a Pi slot in its first half and a CPU slot in its second half. Pi requests arrive from the SPI-clocked command block as a level handshake; this block synchronizes them, performs the RAM access, and returns read data plus a done level.

## Interface
Parameters:
- FRAME_LEN, 16: clocks per bus frame; counter is log2(FRAME_LEN) bits. The counter wraps from FRAME_LEN-1 to 0.
- PI_SLOT_END, 7: last count of the Pi slot. Counts PI_SLOT_END+1..FRAME_LEN-1 are the CPU slot.

Ports:
- clk  in  1  system clock (16 MHz); all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pi_pending  in  1  Pi request level, asynchronous to clk. Source holds pi_addr, pi_data_out and pi_rw_b stable while it is high.
- pi_addr  in  17  Pi target address.
- pi_data_out  in  8  Pi write data.
- pi_rw_b  in  1  1 = read, 0 = write.
- pi_done  out  1  access complete. Held high until synchronized pi_pending is seen low.
- pi_data_in  out  8  Pi read data, valid while pi_done = 1.
- cpu_addr  in  16  6502 address.
- cpu_rw_b  in  1  6502 R/W.
- phi2  out  1  CPU clock phase.
- cpu_be  out  1  CPU bus enable.
- ram_addr  out  17  RAM address.
- ram_data_i  in  8  RAM read data.
- ram_data_o  out  8  RAM write data.
- ram_data_oe  out  1  FPGA drives RAM data bus.
- ram_oe_n  out  1  RAM output enable, active-low.
- ram_we_n  out  1  RAM write enable, active-low.

## Operation
- Frame counter `count` runs continuously out of reset, starting at 0.
- phi2 = 1 for counts PI_SLOT_END+1..FRAME_LEN-1 and 0 otherwise. cpu_be follows phi2.
- pi_pending passes through a 2-flop synchronizer to produce `pend_s`.

Pi state machine:
- **IDLE**: at count 0, if pend_s = 1 and pi_done = 0, latch pi_addr, pi_rw_b and pi_data_out, then go to ACCESS. Otherwise remain in IDLE.
- **ACCESS**: occupies counts 1..PI_SLOT_END. Then go to DONE if pend_s = 1, else IDLE.
- **DONE**: pi_done = 1. When pend_s = 0, clear pi_done and go to IDLE.

A new request requires pend_s to go low and then high again. A level still high after DONE never retriggers.

Pi access strobes (registered, referenced to count):
- ram_addr = latched Pi address over counts 1..7.
- Read: ram_oe_n = 0 over counts 2..6. At the count 6 edge, capture ram_data_i into pi_data_in.
- Write: ram_data_oe = 1 over counts 1..7. ram_data_o = latched data. ram_we_n = 0 over counts 3..5.

CPU slot (every frame, regardless of Pi state):
- ram_addr = {1'b0, cpu_addr} over counts 8..15.
- Read: ram_oe_n = 0 over counts 9..15.
- Write: ram_we_n = 0 over counts 10..14. The CPU's data bus is external, so ram_data_oe stays 0.

Outputs outside these windows: ram_oe_n = 1, ram_we_n = 1, ram_data_oe = 0. ram_addr holds its last value.

Reset values: count 0, state IDLE, phi2 0, cpu_be 0, pi_done 0, pi_data_in 0, ram_addr 0, ram_data_o 0, ram_data_oe 0, ram_oe_n 1, ram_we_n 1, synchronizer 0.

## Timing
- Request latency: pi_pending rise → pend_s takes 2 clocks. Access then waits for the next count 0, so the worst case is 2 + FRAME_LEN - 1 = 17 clocks before ACCESS begins.
- Completion: pi_done rises at the count-8 edge of the serving frame.
- pi_data_in stays stable from the count-6 edge until the next Pi read.
- Boundary conditions:
  - pend_s rises at count 1..15: not served until the next count 0.
  - pend_s falls during ACCESS: the access still completes (never aborted, strobes unchanged). pi_done is not asserted; return to IDLE.
  - pend_s high at count 0 while in DONE: no new access.
  - Pi and CPU windows never overlap. No we_n/oe_n pulse spans the count 7→8 boundary.
  - reset_n low mid-access: all outputs go to reset values immediately. A partial write is accepted; the Pi must re-issue.
  - The CPU slot is never stalled or stretched by Pi activity.

## Test plan
- Reset: hold reset_n = 0 → all outputs at reset values. Release → phi2 first high after count 8, with period 16 clocks and 50% duty.
- Pi write: 0x1_8000 ← 0xA5 with pending raised before count 0 → ram_we_n low counts 3..5, ram_addr = 0x18000, ram_data_o = 0xA5, pi_done high at count 8. Drop pending → pi_done low within 3 clocks.
- Pi read: 0x0_0400, with the RAM model returning 0x3C → ram_oe_n low counts 2..6, pi_data_in = 0x3C, pi_done high at count 8.
- Late request: pending raised at count 2 → no strobe in the current frame; access occurs in the next frame. CPU writes to 0x8000 in both frames → ram_we_n low at counts 10..14 and ram_addr = 0x08000.
- Held request: pending held high through DONE for 3 frames → exactly one RAM access. Dropping pending mid-ACCESS → access completes, pi_done never rises.
- Reset mid-write: assert reset_n at count 4 → ram_we_n = 1 and ram_data_oe = 0 immediately. After release, state is IDLE with pi_done = 0.
